// File: rtl/prefix_encode_stream_if.sv
// Request / byte-stream bundle for the x86 prefix encoder.
// The encoder uses the slave view; the requester/byte sink uses the master view.
interface prefix_encode_stream_if;
  // request side
  logic       i_req_valid;
  logic       o_req_ready;
  logic       i_lock;
  logic       i_repne;
  logic       i_rep;
  logic       i_seg_override;
  logic [2:0] i_seg_index;
  logic       i_hint_taken;
  logic       i_hint_not_taken;
  logic       i_operand_size;
  logic       i_address_size;
  // byte stream side
  logic       o_byte_valid;
  logic       i_byte_ready;
  logic [7:0] o_byte;
  logic       o_byte_last;
  // status
  logic [2:0] o_count;
  logic       o_done;
  logic       o_error;

  modport slave (
    input  i_req_valid, i_lock, i_repne, i_rep, i_seg_override, i_seg_index,
           i_hint_taken, i_hint_not_taken, i_operand_size, i_address_size,
           i_byte_ready,
    output o_req_ready, o_byte_valid, o_byte, o_byte_last, o_count, o_done, o_error
  );

  modport master (
    output i_req_valid, i_lock, i_repne, i_rep, i_seg_override, i_seg_index,
           i_hint_taken, i_hint_not_taken, i_operand_size, i_address_size,
           i_byte_ready,
    input  o_req_ready, o_byte_valid, o_byte, o_byte_last, o_count, o_done, o_error
  );
endinterface

// File: rtl/prefix_encode_stream.sv
// x86 prefix encoder: turns one request of prefix attributes into 0-4 legal
// prefix bytes streamed one per handshake, in group order (or reversed).
// Illegal attribute combinations finish with an error pulse and no bytes.
module prefix_encode_stream #(
  parameter bit REVERSE_ORDER = 1'b0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  prefix_encode_stream_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True when at least two of three flags are set (mutually exclusive group).
  function automatic logic more_than_one(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Segment override prefix byte for a segment register index.
  function automatic logic [7:0] seg_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'h26;
      3'd1:    b = 8'h2E;
      3'd2:    b = 8'h36;
      3'd3:    b = 8'h3E;
      3'd4:    b = 8'h64;
      3'd5:    b = 8'h65;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_e          state_q, state_d;
  logic [3:0][7:0] queue_q, queue_d;   // slot 0 is the byte on the stream
  logic [2:0]      rem_q,   rem_d;     // bytes still to be handed over
  logic [2:0]      count_q, count_d;
  logic            err_q,   err_d;

  logic [3:0][7:0] grp_byte_s;         // index 0 = group 1
  logic [3:0]      grp_present_s;
  logic [3:0][7:0] packed_s;
  logic [2:0]      pack_cnt_s;
  logic            req_err_s;
  logic [1:0]      gsel_s;

  // Per-group byte selection and illegal-combination detection.
  always_comb begin
    grp_present_s[0] = bus.i_lock | bus.i_repne | bus.i_rep;
    if (bus.i_lock) begin
      grp_byte_s[0] = 8'hF0;
    end else if (bus.i_repne) begin
      grp_byte_s[0] = 8'hF2;
    end else if (bus.i_rep) begin
      grp_byte_s[0] = 8'hF3;
    end else begin
      grp_byte_s[0] = 8'h00;
    end

    grp_present_s[1] = bus.i_seg_override | bus.i_hint_taken | bus.i_hint_not_taken;
    if (bus.i_seg_override) begin
      grp_byte_s[1] = seg_byte(bus.i_seg_index);
    end else if (bus.i_hint_taken) begin
      grp_byte_s[1] = 8'h3E;
    end else if (bus.i_hint_not_taken) begin
      grp_byte_s[1] = 8'h2E;
    end else begin
      grp_byte_s[1] = 8'h00;
    end

    grp_present_s[2] = bus.i_operand_size;
    grp_byte_s[2]    = 8'h66;
    grp_present_s[3] = bus.i_address_size;
    grp_byte_s[3]    = 8'h67;

    req_err_s = more_than_one(bus.i_lock, bus.i_repne, bus.i_rep)
              | more_than_one(bus.i_seg_override, bus.i_hint_taken, bus.i_hint_not_taken)
              | (bus.i_seg_override & (bus.i_seg_index > 3'd5));
  end

  // Compact present groups into consecutive queue slots in emission order.
  always_comb begin
    packed_s   = '0;
    pack_cnt_s = 3'd0;
    gsel_s     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      gsel_s = REVERSE_ORDER ? 2'(3 - k) : 2'(k);
      if (grp_present_s[gsel_s]) begin
        packed_s[pack_cnt_s[1:0]] = grp_byte_s[gsel_s];
        pack_cnt_s = pack_cnt_s + 3'd1;
      end else begin
        pack_cnt_s = pack_cnt_s;
      end
    end
  end

  // Next-state logic: accept, stream bytes, one-cycle completion.
  always_comb begin
    state_d = state_q;
    queue_d = queue_q;
    rem_d   = rem_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_req_valid) begin
          err_d = req_err_s;
          if (req_err_s) begin
            count_d = 3'd0;
            rem_d   = 3'd0;
            queue_d = '0;
            state_d = ST_DONE;
          end else begin
            count_d = pack_cnt_s;
            rem_d   = pack_cnt_s;
            queue_d = packed_s;
            state_d = (pack_cnt_s == 3'd0) ? ST_DONE : ST_EMIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (bus.i_byte_ready) begin
          queue_d = {8'h00, queue_q[3:1]};
          rem_d   = rem_q - 3'd1;
          if (rem_q == 3'd1) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_EMIT;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight sequence.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      queue_q <= '0;
      rem_q   <= 3'd0;
      count_q <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      queue_q <= queue_d;
      rem_q   <= rem_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Outputs are pure decodes of registered state.
  assign bus.o_req_ready  = (state_q == ST_IDLE);
  assign bus.o_byte_valid = (state_q == ST_EMIT);
  assign bus.o_byte       = (state_q == ST_EMIT) ? queue_q[0] : 8'h00;
  assign bus.o_byte_last  = (state_q == ST_EMIT) && (rem_q == 3'd1);
  assign bus.o_count      = count_q;
  assign bus.o_done       = (state_q == ST_DONE);
  assign bus.o_error      = (state_q == ST_DONE) & err_q;

endmodule

// File: tb/tb_prefix_encode_stream.sv
// Directed bench for prefix_encode_stream: forward-order and reverse-order
// instances, hand-computed byte sequences, stalls, errors and mid-stream reset.
module tb_prefix_encode_stream;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   idx;

  logic       pat  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [7:0] t2_exp [4] = '{8'hF3, 8'h64, 8'h66, 8'h67};

  prefix_encode_stream_if bus0 ();
  prefix_encode_stream_if bus1 ();

  prefix_encode_stream #(.REVERSE_ORDER(1'b0)) dut_fwd (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus0)
  );

  prefix_encode_stream #(.REVERSE_ORDER(1'b1)) dut_rev (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input logic lk, input logic rn, input logic rp, input logic so,
                      input logic [2:0] si, input logic ht, input logic hn,
                      input logic os, input logic as);
    bus0.i_lock = lk; bus0.i_repne = rn; bus0.i_rep = rp;
    bus0.i_seg_override = so; bus0.i_seg_index = si;
    bus0.i_hint_taken = ht; bus0.i_hint_not_taken = hn;
    bus0.i_operand_size = os; bus0.i_address_size = as;
    bus0.i_req_valid = 1'b1;
  endtask

  task automatic clr0();
    req0(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus0.i_req_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    clr0();
    bus0.i_byte_ready = 1'b0;
    bus1.i_req_valid = 1'b0; bus1.i_lock = 1'b0; bus1.i_repne = 1'b0; bus1.i_rep = 1'b0;
    bus1.i_seg_override = 1'b0; bus1.i_seg_index = 3'd0; bus1.i_hint_taken = 1'b0;
    bus1.i_hint_not_taken = 1'b0; bus1.i_operand_size = 1'b0; bus1.i_address_size = 1'b0;
    bus1.i_byte_ready = 1'b0;

    // reset values
    step();
    chk("rst_req_ready", bus0.o_req_ready, 8'h01);
    chk("rst_valid", bus0.o_byte_valid, 8'h00);
    chk("rst_byte", bus0.o_byte, 8'h00);
    chk("rst_last", bus0.o_byte_last, 8'h00);
    chk("rst_count", bus0.o_count, 8'h00);
    chk("rst_done", bus0.o_done, 8'h00);
    chk("rst_error", bus0.o_error, 8'h00);
    rst_n = 1'b1;
    step();

    // LOCK + DS + operand size, continuous ready -> F0,3E,66
    req0(1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    bus0.i_byte_ready = 1'b1;
    chk("t1_req_ready", bus0.o_req_ready, 8'h01);
    step();
    clr0();
    chk("t1_valid0", bus0.o_byte_valid, 8'h01);
    chk("t1_byte0", bus0.o_byte, 8'hF0);
    chk("t1_last0", bus0.o_byte_last, 8'h00);
    chk("t1_count", bus0.o_count, 8'h03);
    chk("t1_busy", bus0.o_req_ready, 8'h00);
    step();
    chk("t1_byte1", bus0.o_byte, 8'h3E);
    chk("t1_last1", bus0.o_byte_last, 8'h00);
    step();
    chk("t1_byte2", bus0.o_byte, 8'h66);
    chk("t1_last2", bus0.o_byte_last, 8'h01);
    step();
    chk("t1_done", bus0.o_done, 8'h01);
    chk("t1_error", bus0.o_error, 8'h00);
    chk("t1_valid_off", bus0.o_byte_valid, 8'h00);
    chk("t1_byte_zero", bus0.o_byte, 8'h00);
    chk("t1_ready_done", bus0.o_req_ready, 8'h00);
    chk("t1_count_done", bus0.o_count, 8'h03);
    step();
    chk("t1_done_pulse", bus0.o_done, 8'h00);
    chk("t1_ready_back", bus0.o_req_ready, 8'h01);
    chk("t1_count_hold", bus0.o_count, 8'h03);

    // empty request -> immediate done, count 0
    req0(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    clr0();
    chk("t3_valid", bus0.o_byte_valid, 8'h00);
    chk("t3_done", bus0.o_done, 8'h01);
    chk("t3_error", bus0.o_error, 8'h00);
    chk("t3_count", bus0.o_count, 8'h00);
    chk("t3_ready_done", bus0.o_req_ready, 8'h00);
    step();
    chk("t3_ready_back", bus0.o_req_ready, 8'h01);
    chk("t3_valid_after", bus0.o_byte_valid, 8'h00);

    // REP + FS + operand + address, ready 1,0,0,1,0,1,1 -> F3,64,66,67
    req0(1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    clr0();
    chk("t2_count", bus0.o_count, 8'h04);
    idx = 0;
    for (int k = 0; k < 7; k++) begin
      bus0.i_byte_ready = pat[k];
      chk("t2_valid", bus0.o_byte_valid, 8'h01);
      chk("t2_byte", bus0.o_byte, t2_exp[idx]);
      chk("t2_last", bus0.o_byte_last, (idx == 3) ? 8'h01 : 8'h00);
      if (pat[k]) begin
        idx++;
      end
      step();
    end
    chk("t2_done", bus0.o_done, 8'h01);
    chk("t2_error", bus0.o_error, 8'h00);
    chk("t2_valid_off", bus0.o_byte_valid, 8'h00);
    step();

    // illegal combinations: REPNE+REP, seg index 6, hint_taken+seg
    for (int e = 0; e < 3; e++) begin
      case (e)
        0:       req0(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        1:       req0(1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        default: req0(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      endcase
      step();
      clr0();
      chk("t4_done", bus0.o_done, 8'h01);
      chk("t4_error", bus0.o_error, 8'h01);
      chk("t4_count", bus0.o_count, 8'h00);
      chk("t4_valid", bus0.o_byte_valid, 8'h00);
      step();
      chk("t4_error_pulse", bus0.o_error, 8'h00);
      chk("t4_ready_back", bus0.o_req_ready, 8'h01);
    end

    // reverse order instance: REPNE + hint_not_taken + 66 + 67 -> 67,66,2E,F2
    bus1.i_repne = 1'b1; bus1.i_hint_not_taken = 1'b1;
    bus1.i_operand_size = 1'b1; bus1.i_address_size = 1'b1;
    bus1.i_byte_ready = 1'b1; bus1.i_req_valid = 1'b1;
    step();
    bus1.i_req_valid = 1'b0; bus1.i_repne = 1'b0; bus1.i_hint_not_taken = 1'b0;
    bus1.i_operand_size = 1'b0; bus1.i_address_size = 1'b0;
    chk("t5_byte0", bus1.o_byte, 8'h67);
    chk("t5_last0", bus1.o_byte_last, 8'h00);
    chk("t5_count", bus1.o_count, 8'h04);
    step();
    chk("t5_byte1", bus1.o_byte, 8'h66);
    step();
    chk("t5_byte2", bus1.o_byte, 8'h2E);
    chk("t5_last2", bus1.o_byte_last, 8'h00);
    step();
    chk("t5_byte3", bus1.o_byte, 8'hF2);
    chk("t5_last3", bus1.o_byte_last, 8'h01);
    step();
    chk("t5_done", bus1.o_done, 8'h01);
    chk("t5_error", bus1.o_error, 8'h00);
    bus1.i_byte_ready = 1'b0;
    step();

    // reset after second handshake of a 4-byte request
    bus0.i_byte_ready = 1'b1;
    req0(1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    clr0();
    step();
    step();
    chk("t6_pre_byte", bus0.o_byte, 8'h66);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", bus0.o_byte_valid, 8'h00);
    chk("t6_byte", bus0.o_byte, 8'h00);
    chk("t6_last", bus0.o_byte_last, 8'h00);
    chk("t6_count", bus0.o_count, 8'h00);
    chk("t6_done", bus0.o_done, 8'h00);
    chk("t6_error", bus0.o_error, 8'h00);
    chk("t6_ready", bus0.o_req_ready, 8'h01);
    step();
    chk("t6_no_done", bus0.o_done, 8'h00);
    rst_n = 1'b1;
    step();
    chk("t6_ready_after", bus0.o_req_ready, 8'h01);
    chk("t6_no_done_after", bus0.o_done, 8'h00);
    req0(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    clr0();
    chk("t6_new_byte", bus0.o_byte, 8'hF0);
    chk("t6_new_last", bus0.o_byte_last, 8'h01);
    chk("t6_new_count", bus0.o_count, 8'h01);
    step();
    chk("t6_new_done", bus0.o_done, 8'h01);
    chk("t6_new_error", bus0.o_error, 8'h00);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
